// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin arbiter sharing one FIFO write port between N_REQ requesters.
// Latency : 1-cycle arbitration (IDLE) before each grant; write path is combinational.
// Backpres: f_full holds the grant and beat count and suppresses ack/wr_en; words wait at the requester.
//
// Ports:
//   wr_clk, reset        clock and synchronous active-high reset
//   req, req_last        per-requester word-valid and final-word marker
//   req_data             packed words, requester i at [i*D_WIDTH +: D_WIDTH]
//   f_full               FIFO full flag
//   gnt, gnt_id, busy    registered one-hot grant, its index, BURST indicator
//   ack, wr_en, wr_data  combinational accept strobes and muxed write data
//
// Optional feature macro: FIFO_WR_ARB_PRIORITY0_EN
//   defined   -> requester 0 always wins arbitration when requesting; 1..N_REQ-1 rotate.
//   undefined -> pure round-robin over all requesters.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int D_WIDTH   = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       wr_clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           req_last,
    input  logic [N_REQ*D_WIDTH-1:0]   req_data,
    input  logic                       f_full,
    output logic [N_REQ-1:0]           gnt,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic [N_REQ-1:0]           ack,
    output logic                       wr_en,
    output logic [D_WIDTH-1:0]         wr_data,
    output logic                       busy
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int BC_W = $clog2(MAX_BURST) + 1;
    // One extra bit so last_id + k (k <= N_REQ) never overflows before wrapping.
    localparam int CW   = ID_W + 1;
    localparam logic [CW-1:0]   N_CMP    = CW'(N_REQ);
    localparam logic [BC_W-1:0] BEAT_TOP = BC_W'(MAX_BURST - 1);
    localparam logic [N_REQ-1:0] ONEHOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t              state, state_n;
    logic [ID_W-1:0]     last_id, last_id_n;
    logic [ID_W-1:0]     gnt_id_n;
    logic [ID_W-1:0]     sel;
    logic [N_REQ-1:0]    gnt_n;
    logic [BC_W-1:0]     beat_cnt, beat_cnt_n;
    logic                busy_n;
    logic                found;
    logic [CW-1:0]       cand;
    logic                in_burst;
    logic                accept;
    logic                release_gnt;
    logic [D_WIDTH-1:0]  data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*D_WIDTH +: D_WIDTH];
    end

    // Arbitration: scan forward from the slot after the last granted requester.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = '0;
`ifdef FIFO_WR_ARB_PRIORITY0_EN
        if (req[0]) begin
            sel   = '0;
            found = 1'b1;
        end else begin
            // Rotate over 1..N_REQ-1 only; wrapping skips slot 0.
            for (int k = 1; k < N_REQ; k++) begin
                cand = {1'b0, last_id} + CW'(k);
                if (cand >= N_CMP) begin
                    cand = cand - N_CMP + CW'(1);
                end
                if (!found && req[cand[ID_W-1:0]]) begin
                    sel   = cand[ID_W-1:0];
                    found = 1'b1;
                end
            end
        end
`else
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_id} + CW'(k);
            if (cand >= N_CMP) begin
                cand = cand - N_CMP;
            end
            if (!found && req[cand[ID_W-1:0]]) begin
                sel   = cand[ID_W-1:0];
                found = 1'b1;
            end
        end
`endif
    end

    // Reset gates the write path so an abandoned burst never writes in the reset cycle.
    assign in_burst = (state == BURST) && !reset;
    assign accept   = in_burst && req[gnt_id] && !f_full;
    assign wr_en    = accept;
    assign ack      = gnt & {N_REQ{accept}};
    assign wr_data  = in_burst ? data_arr[gnt_id] : '0;

    // Withdrawal releases even while f_full stalls the burst.
    assign release_gnt = (accept && (req_last[gnt_id] || (beat_cnt == BEAT_TOP)))
                       || !req[gnt_id];

    always_comb begin
        state_n    = state;
        gnt_n      = gnt;
        gnt_id_n   = gnt_id;
        busy_n     = busy;
        beat_cnt_n = beat_cnt;
        last_id_n  = last_id;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n    = BURST;
                    gnt_n      = ONEHOT0 << sel;
                    gnt_id_n   = sel;
                    busy_n     = 1'b1;
                    beat_cnt_n = '0;
                end
            end
            BURST: begin
                if (release_gnt) begin
                    state_n    = IDLE;
                    gnt_n      = '0;
                    gnt_id_n   = '0;
                    busy_n     = 1'b0;
                    beat_cnt_n = '0;
                    last_id_n  = gnt_id;
                end else if (accept) begin
                    beat_cnt_n = beat_cnt + BC_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            // Last-granted = N_REQ-1 makes requester 0 the first winner after reset.
            last_id  <= ID_W'(N_REQ - 1);
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            busy     <= busy_n;
            beat_cnt <= beat_cnt_n;
            last_id  <= last_id_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose : self-checking bench for fifo_wr_arbiter (N_REQ=4, D_WIDTH=8, MAX_BURST=4).
// Latency : directed per-cycle rows give inputs plus expected gnt/wr_en; accepted words go to a scoreboard.
// Backpres: requesters advance their word only when ack is seen, so a misdirected ack corrupts later data.
module tb_fifo_wr_arbiter;

    logic        wr_clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic        f_full;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic [3:0]  ack;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        busy;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter #(
        .N_REQ(4),
        .D_WIDTH(8),
        .MAX_BURST(4)
    ) dut (
        .wr_clk(wr_clk),
        .reset(reset),
        .req(req),
        .req_last(req_last),
        .req_data(req_data),
        .f_full(f_full),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .ack(ack),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .busy(busy)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] rq;
        logic [3:0] lst;
        logic       ff;
        logic [3:0] g;
        logic       we;
    } row_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    row_t rows[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   wcnt[4];
    int   exp_cnt[4];

    // Word presented by requester i after c accepted words.
    function automatic logic [7:0] mk(int i, int c);
        return 8'((i << 5) | (c & 31));
    endfunction

    function automatic logic [1:0] idx(logic [3:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req_val);
        checks++;
        if (act !== req_val) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req_val, $time);
        end
    endtask

    task automatic add(logic rst, logic [3:0] rq, logic [3:0] lst, logic ff,
                       logic [3:0] g, logic we);
        rows.push_back('{rst, rq, lst, ff, g, we});
    endtask

    // Requester model: each requester steps to its next word on an ack.
    always @(posedge wr_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) wcnt[i] <= wcnt[i] + 1;
        end
    end

    always_comb begin
        req_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = mk(i, wcnt[i]);
        end
    end

    // Monitor: every write on the FIFO bus must match the next expected word.
    always @(negedge wr_clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: id %0d data %0h, required no write (t=%0t)",
                         gnt_id, wr_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_id", 32'(gnt_id), 32'(e.id));
                chk("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] g;
        reset    = 1'b1;
        req      = '0;
        req_last = '0;
        f_full   = 1'b0;

        // Reset with everything requesting: nothing granted, nothing written.
        add(1, 4'hF, 4'hF, 0, 4'h0, 0);
        add(1, 4'hF, 4'hF, 0, 4'h0, 0);
        // Two-word burst on requester 0, last on 2nd word.
        add(0, 4'h1, 4'h0, 0, 4'h0, 0);
        add(0, 4'h1, 4'h0, 0, 4'h1, 1);
        add(0, 4'h1, 4'h1, 0, 4'h1, 1);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0);
        // Reset reloads last_id so the rotation below starts at 0.
        add(1, 4'h0, 4'h0, 0, 4'h0, 0);
        // All requesting, no last: 4-word bursts plus one idle cycle each.
        for (int k = 0; k < 5; k++) begin
`ifdef FIFO_WR_ARB_PRIORITY0_EN
            g = 2'd0;
`else
            g = 2'(k % 4);
`endif
            add(0, 4'hF, 4'h0, 0, 4'h0, 0);
            for (int b = 0; b < 4; b++) add(0, 4'hF, 4'h0, 0, 4'(1 << g), 1);
        end
        add(0, 4'h0, 4'h0, 0, 4'h0, 0);
        // Requester 2 stalled by f_full for 3 cycles after its first word.
        add(0, 4'h4, 4'h0, 0, 4'h0, 0);
        add(0, 4'h4, 4'h0, 0, 4'h4, 1);
        for (int s = 0; s < 3; s++) add(0, 4'h4, 4'h0, 1, 4'h4, 0);
        for (int s = 0; s < 3; s++) add(0, 4'h4, 4'h0, 0, 4'h4, 1);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0);
        // Requester 1 withdraws after one word; requester 3 waiting (its last is ignored while 1 holds).
        add(0, 4'h2, 4'h0, 0, 4'h0, 0);
        add(0, 4'h2, 4'h0, 0, 4'h2, 1);
        add(0, 4'h8, 4'h8, 0, 4'h2, 0);
        add(0, 4'h8, 4'h8, 0, 4'h0, 0);
        add(0, 4'h8, 4'h8, 0, 4'h8, 1);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0);
        // Reset mid-burst on requester 3; next arbitration grants 0.
        add(0, 4'h8, 4'h0, 0, 4'h0, 0);
        add(0, 4'h8, 4'h0, 0, 4'h8, 1);
        add(1, 4'h8, 4'h0, 0, 4'h8, 0);
        add(0, 4'hF, 4'h0, 0, 4'h0, 0);
        add(0, 4'hF, 4'h0, 0, 4'h1, 1);
        add(0, 4'h0, 4'h0, 0, 4'h1, 0);
        add(0, 4'h0, 4'h0, 0, 4'h0, 0);
`ifdef FIFO_WR_ARB_PRIORITY0_EN
        // Requester 0 wins every arbitration while requesting; then 1,2,3 rotate.
        for (int r = 0; r < 2; r++) begin
            add(0, 4'hF, 4'h0, 0, 4'h0, 0);
            for (int b = 0; b < 4; b++) add(0, 4'hF, 4'h0, 0, 4'h1, 1);
        end
        for (int r = 1; r < 4; r++) begin
            add(0, 4'hE, 4'h0, 0, 4'h0, 0);
            for (int b = 0; b < 4; b++) add(0, 4'hE, 4'h0, 0, 4'(1 << r), 1);
        end
        add(0, 4'h0, 4'h0, 0, 4'h0, 0);
`endif

        @(posedge wr_clk);
        #1;
        foreach (rows[n]) begin
            reset    = rows[n].rst;
            req      = rows[n].rq;
            req_last = rows[n].lst;
            f_full   = rows[n].ff;
            if (rows[n].we) begin
                g = idx(rows[n].g);
                exp_q.push_back('{g, mk(int'(g), exp_cnt[g])});
                exp_cnt[g]++;
            end
            @(negedge wr_clk);
            chk($sformatf("gnt[row %0d]", n), 32'(gnt), 32'(rows[n].g));
            chk($sformatf("gnt_id[row %0d]", n), 32'(gnt_id), 32'(idx(rows[n].g)));
            chk($sformatf("busy[row %0d]", n), 32'(busy), 32'(|rows[n].g));
            chk($sformatf("wr_en[row %0d]", n), 32'(wr_en), 32'(rows[n].we));
            chk($sformatf("ack[row %0d]", n), 32'(ack), 32'(rows[n].we ? rows[n].g : 4'h0));
            @(posedge wr_clk);
            #1;
        end
        chk("words_outstanding", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one FIFO write side between N_REQ requesters.
- Grants one requester at a time for a bounded burst and muxes its data onto the FIFO write bus.
- Stalls on f_full; sits directly in front of the write control / memory write port.
- Single clock domain (wr_clk).

Parameters:
- N_REQ, 4, number of requesters (2..8).
- D_WIDTH, 8, data word width.
- MAX_BURST, 4, maximum accepted words per grant (1..16).

Ports:
- wr_clk  input  1  write-domain clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request; held high while the requester has a word valid.
- req_last  input  N_REQ  marks the current word as the requester's final burst word.
- req_data  input  N_REQ*D_WIDTH  packed data; requester i occupies bits [i*D_WIDTH +: D_WIDTH].
- f_full  input  1  FIFO full flag from the write-side flag logic.
- gnt  output  N_REQ  registered one-hot grant (all zero when idle).
- gnt_id  output  $clog2(N_REQ)  registered index of the granted requester; 0 when idle.
- ack  output  N_REQ  combinational; word of requester i accepted this cycle.
- wr_en  output  1  combinational FIFO write enable.
- wr_data  output  D_WIDTH  combinational; data of the granted requester, 0 when idle.
- busy  output  1  registered; high in state BURST.

Behaviour:
- Reset (synchronous, reset=1 at edge): state=IDLE; gnt=0; gnt_id=0; busy=0; beat_cnt=0; last_id=N_REQ-1, so requester 0 wins first. While reset is high, ack and wr_en are 0 regardless of inputs.
- States: IDLE, BURST.
- IDLE:
  - If any req bit is high, select the first requester at or after last_id+1 (modulo N_REQ) with req=1.
  - Next edge: gnt=onehot(sel), gnt_id=sel, beat_cnt=0, state=BURST.
  - Arbitration latency is 1 cycle; no word is accepted in IDLE.
- BURST, combinational outputs:
  - accept = req[gnt_id] & ~f_full.
  - ack[gnt_id] = accept; all other ack bits are 0.
  - wr_en = accept.
  - wr_data = req_data slice gnt_id, driven whenever in BURST.
- BURST, on each edge with accept=1: beat_cnt increments.
- Grant release: occurs on the edge where any of the following holds.
  - accept & req_last[gnt_id].
  - accept & beat_cnt==MAX_BURST-1.
  - req[gnt_id]==0 (requester withdrew).
- On release: last_id=gnt_id, gnt=0, state=IDLE. There is one bubble cycle before the next grant; re-arbitration happens in IDLE.
- f_full=1 in BURST: no ack and no wr_en; beat_cnt holds; grant holds indefinitely; the word must be held by the requester.
- Simultaneous accept and release condition: the word is written and the grant is released on the same edge.
- Non-granted requester raising req: ignored until the next IDLE arbitration; no priority inversion beyond one burst.
- beat_cnt width is $clog2(MAX_BURST)+1 bits; it never wraps because release occurs at MAX_BURST-1.
- Reset asserted mid-BURST: grant dropped on that edge; any partial burst is abandoned; no write occurs in that cycle.
- req_last on a non-granted requester has no effect.

Optional Feature:
- Macro: FIFO_WR_ARB_PRIORITY0_EN.
- Defined: requester 0 is strict high priority. In IDLE, if req[0]=1 it is always selected; the others use round-robin among 1..N_REQ-1 using last_id. MAX_BURST still bounds requester 0's burst.
- Undefined: pure round-robin as above.

Test Plan:
- Reset, then req=4'b0001, data0=0xA1, req_last[0] on 2nd word, f_full=0:
  - gnt=0001 one cycle after req.
  - wr_en high 2 cycles with data 0xA1 then next word.
  - gnt=0 after the last ack; busy falls with it.
- req=4'b1111 continuously, req_last never, MAX_BURST=4:
  - Grants rotate 0,1,2,3,0.
  - Each grant carries exactly 4 wr_en pulses, followed by 1 idle cycle.
- Requester 2 granted, f_full=1 for 3 cycles after its 1st word:
  - wr_en=0 and ack=0 for 3 cycles; gnt stays 0100; beat_cnt stays 1.
  - Bursting resumes; total 4 words.
- Requester 1 granted, req[1] dropped after 1 word while req[3]=1:
  - Grant is released on the drop edge.
  - gnt=1000 two cycles later (one IDLE cycle, then the grant registers); last_id=1.
- Assert reset mid-burst on requester 3 with f_full=0:
  - ack=0 and wr_en=0 in the reset cycle; gnt=0 after the edge.
  - Next arbitration with req=1111 grants requester 0.
- FIFO_WR_ARB_PRIORITY0_EN defined, req=1111:
  - Requester 0 is granted after every release, since it is always requesting.
  - With req[0] deasserted, requesters 1,2,3 rotate.
